// File: rtl/sprite_rom_arbiter_pkg.sv
// Shared sprite geometry, pixel constants and helpers for the sprite ROM arbiter.
package sprite_rom_arbiter_pkg;

  localparam int REL_BITS             = 7;
  localparam int PIXEL_COLOR_BITS     = 8;
  localparam int PIXELS_WIDTH         = 80;
  localparam int SPRITE_REQ_DISPLAY   = 0;
  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef logic [REL_BITS-1:0]         rel_t;
  typedef logic [PIXEL_COLOR_BITS-1:0] pixel_t;

  localparam pixel_t BLACK_PIXEL = 8'b0000_0000;
  localparam rel_t   BOX_EDGE    = rel_t'(PIXELS_WIDTH);

  function automatic logic is_oob(input rel_t x, input rel_t y);
    return (x >= BOX_EDGE) || (y >= BOX_EDGE);
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker over requesters 1..NUM_REQ-1, starting at ptr.
module sprite_rom_arbiter_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:1] req_lo,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every variable written here gets a default first so no path can infer a latch.
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      // Walk ptr, ptr+1, ... wrapping from NUM_REQ-1 back to 1; index 0 never competes.
      idx = IDX_W'(((int'(ptr) - 1 + k) % (NUM_REQ - 1)) + 1);
      if (!found && req_lo[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Arbitrates one combinational sprite ROM port between a display requester and
// round-robin low-priority requesters; two-stage pipeline returns a tagged pixel.
module sprite_rom_arbiter
  import sprite_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*REL_BITS-1:0]   req_x,
  input  logic [NUM_REQ*REL_BITS-1:0]   req_y,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [REL_BITS-1:0]           rom_x,
  output logic [REL_BITS-1:0]           rom_y,
  input  logic [PIXEL_COLOR_BITS-1:0]   rom_pixels,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [PIXEL_COLOR_BITS-1:0]   rsp_pixel,
  output logic                          rsp_oob
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] FIRST_LO   = IDX_W'(1);

  logic [IDX_W-1:0]   ptr_q,       ptr_d;
  logic [CNT_W-1:0]   starve_q,    starve_d;
  logic               s1_valid_q,  s1_valid_d;
  logic [IDX_W-1:0]   s1_tag_q,    s1_tag_d;
  logic               s1_oob_q,    s1_oob_d;
  rel_t               rom_x_q,     rom_x_d;
  rel_t               rom_y_q,     rom_y_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  pixel_t             rsp_pixel_q, rsp_pixel_d;
  logic               rsp_oob_q,   rsp_oob_d;

  logic [NUM_REQ-1:0] rr_gnt;
  logic               lo_req;
  logic               lo_gnt;
  logic [IDX_W-1:0]   win_idx;
  rel_t               win_x;
  rel_t               win_y;
  logic               win_oob;

  sprite_rom_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_lo (req[NUM_REQ-1:1]),
    .ptr    (ptr_q),
    .pick   (rr_gnt)
  );

  assign lo_req = |req[NUM_REQ-1:1];
  assign lo_gnt = |gnt[NUM_REQ-1:1];

  always_comb begin
    gnt = '0;
    if (starve_q == STARVE_MAX && lo_req) begin
      gnt = rr_gnt;
    end else if (req[SPRITE_REQ_DISPLAY]) begin
      gnt[SPRITE_REQ_DISPLAY] = 1'b1;
    end else begin
      gnt = rr_gnt;
    end
  end

  always_comb begin
    win_idx = '0;
    win_x   = '0;
    win_y   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_idx = IDX_W'(i);
        win_x   = req_x[i*REL_BITS +: REL_BITS];
        win_y   = req_y[i*REL_BITS +: REL_BITS];
      end
    end
    win_oob = is_oob(win_x, win_y);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (lo_gnt) begin
      ptr_d = (win_idx == LAST_IDX) ? FIRST_LO : win_idx + 1'b1;
    end

    starve_d = starve_q;
    if (!lo_req || lo_gnt) begin
      starve_d = '0;
    end else if (gnt[SPRITE_REQ_DISPLAY] && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end

    // Idle cycles hold the address so the ROM sees no toggling.
    s1_valid_d = |gnt;
    s1_tag_d   = s1_tag_q;
    s1_oob_d   = s1_oob_q;
    rom_x_d    = rom_x_q;
    rom_y_d    = rom_y_q;
    if (|gnt) begin
      s1_tag_d = win_idx;
      s1_oob_d = win_oob;
      rom_x_d  = win_oob ? '0 : win_x;
      rom_y_d  = win_oob ? '0 : win_y;
    end

    rsp_valid_d = '0;
    rsp_pixel_d = rsp_pixel_q;
    rsp_oob_d   = rsp_oob_q;
    if (s1_valid_q) begin
      rsp_valid_d = NUM_REQ'(1) << s1_tag_q;
      rsp_pixel_d = s1_oob_q ? BLACK_PIXEL : rom_pixels;
      rsp_oob_d   = s1_oob_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      ptr_q       <= FIRST_LO;
      starve_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_tag_q    <= '0;
      s1_oob_q    <= 1'b0;
      rom_x_q     <= '0;
      rom_y_q     <= '0;
      rsp_valid_q <= '0;
      rsp_pixel_q <= '0;
      rsp_oob_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      starve_q    <= starve_d;
      s1_valid_q  <= s1_valid_d;
      s1_tag_q    <= s1_tag_d;
      s1_oob_q    <= s1_oob_d;
      rom_x_q     <= rom_x_d;
      rom_y_q     <= rom_y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pixel_q <= rsp_pixel_d;
      rsp_oob_q   <= rsp_oob_d;
    end
  end

  assign rom_x     = rom_x_q;
  assign rom_y     = rom_y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_pixel = rsp_pixel_q;
  assign rsp_oob   = rsp_oob_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_sprite_rom_arbiter;
  import sprite_rom_arbiter_pkg::*;

  localparam int NR = 3;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NR-1:0]          req = '0;
  logic [NR*REL_BITS-1:0] req_x;
  logic [NR*REL_BITS-1:0] req_y;
  logic [NR-1:0]          gnt;
  rel_t                   rom_x;
  rel_t                   rom_y;
  pixel_t                 rom_pixels;
  logic [NR-1:0]          rsp_valid;
  pixel_t                 rsp_pixel;
  logic                   rsp_oob;

  rel_t rx [NR];
  rel_t ry [NR];

  typedef struct {
    logic [NR-1:0] valid;
    pixel_t        pix;
    logic          oob;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  sprite_rom_arbiter #(
    .NUM_REQ      (NR),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .gnt        (gnt),
    .rom_x      (rom_x),
    .rom_y      (rom_y),
    .rom_pixels (rom_pixels),
    .rsp_valid  (rsp_valid),
    .rsp_pixel  (rsp_pixel),
    .rsp_oob    (rsp_oob)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < NR; i++) begin
      req_x[i*REL_BITS +: REL_BITS] = rx[i];
      req_y[i*REL_BITS +: REL_BITS] = ry[i];
    end
  end

  // Sprite ROM model: yellow disc of radius 20 centred at (40,40), black elsewhere.
  always_comb begin
    int dx;
    int dy;
    dx = int'(rom_x) - 40;
    dy = int'(rom_y) - 40;
    rom_pixels = (dx * dx + dy * dy <= 400) ? 8'h3F : 8'h00;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_xy(input int i, input int x, input int y);
    rx[i] = rel_t'(x);
    ry[i] = rel_t'(y);
  endtask

  // One cycle of stimulus: drive req after the edge, check gnt mid-cycle, queue the response.
  task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] e_gnt,
                      input pixel_t e_pix, input logic e_oob, input bit push = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    req = r;
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(e_gnt));
    if (push && e_gnt != '0) begin
      e.valid = e_gnt;
      e.pix   = e_pix;
      e.oob   = e_oob;
      e.cyc   = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},       32'(gnt),       0);
    check({tag, "_rom_x"},     32'(rom_x),     0);
    check({tag, "_rom_y"},     32'(rom_y),     0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_pixel"}, 32'(rsp_pixel), 0);
    check({tag, "_rsp_oob"},   32'(rsp_oob),   0);
  endtask

  always @(negedge clk) begin
    check("gnt_without_req", 32'(gnt & ~req), 0);
    if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: rsp_valid=%b with no lookup outstanding (t=%0t)", rsp_valid, $time);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_tag",   32'(rsp_valid), 32'(mon_e.valid));
        check("rsp_pixel", 32'(rsp_pixel), 32'(mon_e.pix));
        check("rsp_oob",   32'(rsp_oob),   32'(mon_e.oob));
        check("rsp_cycle", 32'(cyc),       32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NR; i++) set_xy(i, 0, 0);
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Display requester alone.
    set_xy(0, 40, 40);
    step(3'b001, 3'b001, 8'h3F, 1'b0);
    step(3'b000, 3'b000, 8'h00, 1'b0);

    // Two low-priority requesters alternate.
    set_xy(1, 0, 0);
    set_xy(2, 40, 40);
    step(3'b110, 3'b010, 8'h00, 1'b0);
    step(3'b110, 3'b100, 8'h3F, 1'b0);
    step(3'b110, 3'b010, 8'h00, 1'b0);
    step(3'b110, 3'b100, 8'h3F, 1'b0);
    step(3'b000, 3'b000, 8'h00, 1'b0);
    check("rom_x_hold", 32'(rom_x), 40);
    check("rom_y_hold", 32'(rom_y), 40);

    // Starvation override after four display grants.
    set_xy(0, 40, 40);
    set_xy(1, 0, 0);
    repeat (4) step(3'b011, 3'b001, 8'h3F, 1'b0);
    step(3'b011, 3'b010, 8'h00, 1'b0);
    repeat (2) step(3'b011, 3'b001, 8'h3F, 1'b0);
    step(3'b000, 3'b000, 8'h00, 1'b0);

    // Out-of-box coordinates and the disc edge.
    set_xy(1, PIXELS_WIDTH, 5);
    step(3'b010, 3'b010, 8'h00, 1'b1);
    step(3'b000, 3'b000, 8'h00, 1'b0);
    check("oob_rom_x", 32'(rom_x), 0);
    check("oob_rom_y", 32'(rom_y), 0);
    set_xy(2, 3, PIXELS_WIDTH);
    step(3'b100, 3'b100, 8'h00, 1'b1);
    set_xy(1, 60, 40);
    step(3'b010, 3'b010, 8'h3F, 1'b0);
    step(3'b000, 3'b000, 8'h00, 1'b0);
    check("edge_rom_x", 32'(rom_x), 60);
    check("edge_rom_y", 32'(rom_y), 40);

    // Three back-to-back grants to different requesters.
    set_xy(0, 40, 40);
    step(3'b001, 3'b001, 8'h3F, 1'b0);
    set_xy(1, 20, 40);
    step(3'b010, 3'b010, 8'h3F, 1'b0);
    set_xy(2, 0, 0);
    step(3'b100, 3'b100, 8'h00, 1'b0);
    repeat (2) step(3'b000, 3'b000, 8'h00, 1'b0);

    // Reset between a grant and its response drops the lookup.
    step(3'b001, 3'b001, 8'h3F, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step(3'b000, 3'b000, 8'h00, 1'b0);
    check_all_zero("postrst");
    set_xy(1, 40, 40);
    step(3'b010, 3'b010, 8'h3F, 1'b0);
    repeat (3) step(3'b000, 3'b000, 8'h00, 1'b0);

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one combinational sprite-graphic lookup port (x, y in; 8-bit pixel colour out, PIXELS_WIDTH x PIXELS_WIDTH box) between NUM_REQ requesters.
- Requester 0 is the VGA pixel renderer. Requesters 1..NUM_REQ-1 are collision probes and the animation/score logic.
- Sits between the game-logic/display layer and the sprite box ROM.
- Registers the ROM address, captures the ROM data, and returns a tagged response two cycles after grant.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 is the high-priority display port.
- STARVE_LIMIT, 4, consecutive cycles a pending low-priority requester may be denied before it overrides requester 0.
- REL_BITS, from pacman_definitions.v, width of sprite-relative coordinates.
- PIXEL_COLOR_BITS, from pacman_definitions.v, pixel width (8).
- PIXELS_WIDTH, from pacman_definitions.v, sprite box edge in pixels.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request; held with coordinates until granted.
- req_x  in  NUM_REQ*REL_BITS  flattened x coordinates; slice i belongs to requester i.
- req_y  in  NUM_REQ*REL_BITS  flattened y coordinates.
- gnt  out  NUM_REQ  combinational one-hot grant in the same cycle as req; at most one bit set.
- rom_x  out  REL_BITS  registered lookup x to the sprite ROM.
- rom_y  out  REL_BITS  registered lookup y to the sprite ROM.
- rom_pixels  in  PIXEL_COLOR_BITS  combinational ROM data for rom_x/rom_y.
- rsp_valid  out  NUM_REQ  registered one-hot response strobe, one cycle wide.
- rsp_pixel  out  PIXEL_COLOR_BITS  registered response pixel; valid only when a rsp_valid bit is set.
- rsp_oob  out  1  registered; response coordinates were outside the sprite box.

Behaviour:
- Reset: gnt=0, rom_x=0, rom_y=0, rsp_valid=0, rsp_pixel=0, rsp_oob=0. Round-robin pointer=1. Starvation counter=0. Stage-1 valid=0.
- Reset mid-operation: in-flight lookups are dropped and no rsp_valid is issued for them. Requesters re-request after reset.
- Grant selection (combinational, cycle T):
  - If the starvation counter equals STARVE_LIMIT and any req[1..] is set, grant the round-robin winner among 1..NUM_REQ-1.
  - Otherwise, if req[0] is set, grant 0.
  - Otherwise, grant the round-robin winner among 1..NUM_REQ-1, if any request is set.
- Round-robin: search starts at the pointer and wraps from NUM_REQ-1 back to 1. After a low-priority grant, the pointer moves to the granted index+1, wrapping to 1. The pointer is unchanged on a grant to 0 or on an idle cycle.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on each cycle where some req[1..] is set and gnt[0] is set.
  - Clears on any low-priority grant, or when no req[1..] is set.
- Pipeline, one grant accepted per cycle, fully pipelined with no bubbles:
  - Edge ending T: stage 1 captures the winner's x/y into rom_x/rom_y, the winner index as tag, stage-1 valid, and oob = (x>=PIXELS_WIDTH)||(y>=PIXELS_WIDTH).
  - Edge ending T+1: stage 2 captures rsp_pixel = oob ? 0 : rom_pixels, along with rsp_oob and the tag. rsp_valid[tag] is high during T+2.
  - Latency from req to rsp_valid is 2 cycles.
- Idle cycle (no req): stage-1 valid=0. rom_x/rom_y hold their previous values, so the ROM sees no address change. The following cycle has rsp_valid=0.
- Out-of-range coordinates never index the ROM array: rom_x/rom_y are forced to 0 when oob, and the pixel returned is black (0).
- Requesters may change coordinates or drop req freely when not granted. The bench checks that gnt is never set for a requester whose req is low.

Decomposition:
- pacman_definitions.v (shared include) gains: SPRITE_REQ_DISPLAY=0, the STARVE_LIMIT default, and BLACK_PIXEL=8'b00000000. REL_BITS, PIXEL_COLOR_BITS and PIXELS_WIDTH come from the same include.
- One natural sub-module, rr_pick: combinational round-robin picker over requesters 1..NUM_REQ-1 given the pointer, outputting a one-hot result. Stage registers and the starvation counter stay in sprite_rom_arbiter.

Test Plan:
- Reset, then req=3'b001 with (40,40), ROM model = yellow disc radius 20 centred at 40: gnt=001 same cycle; rsp_valid=001 two cycles later; rsp_pixel=8'h3F; rsp_oob=0.
- req=3'b110 held, requests at (0,0) and (40,40): grants alternate 010,100,010…; responses alternate rsp_pixel 8'h00 and 8'h3F, with tags matching the grants.
- req[0] held every cycle, req[1] held, STARVE_LIMIT=4: gnt=001 for 4 cycles, gnt=010 on cycle 5, counter cleared, then 001 again.
- Requester 1 at (PIXELS_WIDTH, 5): rsp_pixel=0, rsp_oob=1, rom_x=0, rom_y=0.
- Back-to-back grants on 3 consecutive cycles: 3 consecutive rsp_valid strobes, in order, with correct tags and no gaps.
- Assert rst between a grant and its response: rsp_valid stays 0 for that lookup; all outputs read 0 until the next grant's response.
